// File: rtl/ysyx_idu_pkg.sv
// Shared decode definitions for the IDU stage: op-class codes, RV32 opcodes,
// immediate formats and skid-buffer state codes.
package ysyx_idu_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8,
        OP_FENCE  = 4'd9,
        OP_SYSTEM = 4'd10,
        OP_ILL    = 4'd11
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_Z
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // All immediates sign-extend from inst[31]; B/J are halfword offsets.
    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] inst);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_idu_decoder.sv
// Combinational RV32I decoder. Define YSYX_IDU_RVM_EN to accept the
// M-extension (funct7=0x01 on OP) instead of flagging it illegal.
module ysyx_idu_decoder
    import ysyx_idu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] inst_i,
    output logic [3:0]        op_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              wen_o,
    output logic              muldiv_o,
    output logic              illegal_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    op_class_e  cls;
    imm_fmt_e   fmt;
    logic       writes;
    logic       is_muldiv;
    logic       legal_op;
    logic       legal_shift;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        is_muldiv = 1'b0;
`ifdef YSYX_IDU_RVM_EN
        is_muldiv = (funct7 == F7_MULDIV);
`endif
        legal_op = (funct7 == F7_BASE)
                 || ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                 || is_muldiv;
    end

    // Only the shift encodings of OP-IMM constrain funct7.
    always_comb begin
        case (funct3)
            3'b001:  legal_shift = (funct7 == F7_BASE);
            3'b101:  legal_shift = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            default: legal_shift = 1'b1;
        endcase
    end

    always_comb begin
        cls    = OP_ILL;
        fmt    = IMM_Z;
        writes = 1'b0;
        if (inst_i[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI:    begin cls = OP_LUI;    fmt = IMM_U; writes = 1'b1; end
                OPC_AUIPC:  begin cls = OP_AUIPC;  fmt = IMM_U; writes = 1'b1; end
                OPC_JAL:    begin cls = OP_JAL;    fmt = IMM_J; writes = 1'b1; end
                OPC_JALR:   begin cls = OP_JALR;   fmt = IMM_I; writes = 1'b1; end
                OPC_BRANCH: begin cls = OP_BRANCH; fmt = IMM_B; end
                OPC_LOAD:   begin cls = OP_LOAD;   fmt = IMM_I; writes = 1'b1; end
                OPC_STORE:  begin cls = OP_STORE;  fmt = IMM_S; end
                OPC_OPIMM: begin
                    if (legal_shift) begin
                        cls    = OP_OPIMM;
                        fmt    = IMM_I;
                        writes = 1'b1;
                    end
                end
                OPC_OP: begin
                    if (legal_op) begin
                        cls    = OP_OP;
                        writes = 1'b1;
                    end
                end
                OPC_FENCE:  cls = OP_FENCE;
                OPC_SYSTEM: begin cls = OP_SYSTEM; fmt = IMM_I; writes = 1'b1; end
                default: ;
            endcase
        end
    end

    assign op_o      = cls;
    assign rd_o      = inst_i[11:7];
    assign rs1_o     = inst_i[19:15];
    assign rs2_o     = inst_i[24:20];
    assign imm_o     = DATA_W'(gen_imm(fmt, inst_i[31:0]));
    assign wen_o     = writes && (inst_i[11:7] != 5'd0);
    assign illegal_o = (cls == OP_ILL);
`ifdef YSYX_IDU_RVM_EN
    assign muldiv_o  = (cls == OP_OP) && is_muldiv;
`else
    assign muldiv_o  = 1'b0;
`endif

endmodule

// File: rtl/ysyx_idu_stage.sv
// Decode stage: decodes at enqueue into a 2-entry registered skid buffer.
// Honours YSYX_IDU_RVM_EN through the decoder.
module ysyx_idu_stage
    import ysyx_idu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush,
    input  logic              next_ready,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [3:0]        op_o,
    output logic [2:0]        funct3_o,
    output logic              alt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              wen_o,
    output logic              muldiv_o,
    output logic              illegal_o
);

    localparam int ENTRY_W = ADDR_W + 2 * DATA_W + 26;

    logic [1:0]         state_q, state_d;
    logic [ENTRY_W-1:0] e0_q, e0_d;
    logic [ENTRY_W-1:0] e1_q, e1_d;
    logic [ENTRY_W-1:0] new_entry;
    logic               push;
    logic               pop;

    logic [3:0]         dec_op;
    logic [4:0]         dec_rd;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic [DATA_W-1:0]  dec_imm;
    logic               dec_wen;
    logic               dec_muldiv;
    logic               dec_illegal;

    ysyx_idu_decoder #(
        .DATA_W (DATA_W)
    ) u_decoder (
        .inst_i    (inst_i),
        .op_o      (dec_op),
        .rd_o      (dec_rd),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .imm_o     (dec_imm),
        .wen_o     (dec_wen),
        .muldiv_o  (dec_muldiv),
        .illegal_o (dec_illegal)
    );

    assign new_entry = {pc_i, inst_i, dec_op, inst_i[14:12], inst_i[30],
                        dec_rd, dec_rs1, dec_rs2, dec_imm,
                        dec_wen, dec_muldiv, dec_illegal};

    // Handshake depends only on registered state, breaking the next_ready path.
    assign ready_o = (state_q != ST_FULL);
    assign valid_o = (state_q != ST_EMPTY);
    assign push    = prev_valid && ready_o && !flush;
    assign pop     = valid_o && next_ready;

    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        e0_d    = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        e0_d = new_entry;
                    end else if (push) begin
                        e1_d    = new_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        e0_d    = e1_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign {pc_o, inst_o, op_o, funct3_o, alt_o, rd_o, rs1_o, rs2_o,
            imm_o, wen_o, muldiv_o, illegal_o} = e0_q;

endmodule

// File: doc/ysyx_idu_stage.md
Name: ysyx_idu_stage

Overview:
Decode stage directly downstream of the instruction fetch unit. It consumes the fetched instruction and its PC over a valid/ready handshake and decodes RV32I fields at enqueue. It holds results in a 2-entry registered skid buffer and presents them, registered, to the execute stage. A flush input discards all buffered instructions on a front-end redirect.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, instruction/immediate width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
prev_valid  in  1  fetch stage presents inst_i/pc_i
ready_o  out  1  stage can accept this cycle
inst_i  in  DATA_W  fetched instruction
pc_i  in  ADDR_W  PC of inst_i
flush  in  1  discard all buffered entries (redirect)
next_ready  in  1  execute stage accepts head entry
valid_o  out  1  head entry valid
pc_o  out  ADDR_W  head PC
inst_o  out  DATA_W  head raw instruction
op_o  out  4  opcode class (package enum)
funct3_o  out  3  inst[14:12]
alt_o  out  1  inst[30] (SUB/SRA select)
rd_o, rs1_o, rs2_o  out  5 each  register indices
imm_o  out  DATA_W  sign-extended immediate
wen_o  out  1  writes rd (rd!=0 and class writes)
muldiv_o  out  1  M-extension op (0 when feature off)
illegal_o  out  1  undecodable instruction

Behaviour:
- Reset (async, rst=1): count=0, valid_o=0, ready_o=1, all other outputs 0.
- Buffer: entries E0 (head) and E1; count in {0,1,2}; states EMPTY, ONE, FULL.
- ready_o = (count != 2). Derived only from registered count; no combinational path from next_ready.
- push = prev_valid & ready_o & !flush. pop = valid_o & next_ready. valid_o = (count != 0).
- Latency: instruction pushed in cycle N appears on outputs in cycle N+1.
- Decode happens on inst_i at push; decoded fields are stored in the entry. Outputs always reflect E0 registers.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push & pop -> ONE (E0 <= new); push only -> FULL (E1 <= new); pop only -> EMPTY.
  - FULL: pop -> ONE (E0 <= E1); push is impossible because ready_o=0.
- flush has priority over push and pop: next count=0 and valid_o=0 the following cycle. prev_valid is ignored in the flush cycle. Entry data need not be cleared.
- Order is strictly preserved. No entry is duplicated or dropped.
- Immediate formats (sign bit inst[31]):
  - I: LOAD/OPIMM/JALR/SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI/AUIPC, low 12 zero.
  - J: JAL, bit0=0.
  - R/FENCE: 0.
- Op classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILL.
- illegal_o=1 (class ILL) when any of:
  - opcode is not in the table;
  - inst[1:0]!=2'b11;
  - OP funct7 is not in {0x00, 0x20 with funct3 in {000,101}};
  - OPIMM shift funct7 is illegal.
- wen_o=0 for BRANCH/STORE/FENCE/ILL and whenever rd=0.

Optional Feature:
YSYX_IDU_RVM_EN
- Defined: OP with funct7=0x01 decodes as class OP, muldiv_o=1, funct3 selects MUL..REMU.
- Undefined: funct7=0x01 gives illegal_o=1, and muldiv_o is tied 0.

Decomposition:
- Shared package/macro header: op-class encodings (4-bit), RV32 opcode constants, immediate-format enum, buffer state encodings.
- One natural sub-module, ysyx_idu_decoder: purely combinational inst -> {op, rd, rs1, rs2, imm, wen, muldiv, illegal}.
- The stage instantiates one decoder on inst_i and owns the buffer FSM.

Test Plan:
- 0x00500093 (addi x1,x0,5), next_ready=1 -> next cycle: valid_o=1, op=OPIMM, rd=1, rs1=0, imm=5, wen=1.
- 0x12345137 (lui x2) -> imm_o=0x12345000, rd=2. 0xFE000EE3 (beq x0,x0,-4) -> op=BRANCH, imm_o=0xFFFFFFFC, wen=0.
- next_ready=0, push pc 0x80000000 and 0x80000004 -> ready_o=0 after second. Third push pc 0x80000008 held off. Release next_ready -> outputs 0x80000000 then 0x80000004 then 0x80000008, with none lost.
- Count=2, assert flush together with prev_valid=1 -> next cycle valid_o=0, ready_o=1, and the flush-cycle instruction never appears.
- 0x022081B3 (mul x3,x1,x2):
  - with YSYX_IDU_RVM_EN -> muldiv_o=1, illegal_o=0;
  - without -> illegal_o=1.
  - 0xFFFFFFFF -> illegal_o=1 in both builds.
- Assert rst asynchronously mid-FULL, between clock edges -> valid_o=0, ready_o=1 immediately. After release, a new push is accepted normally.
